pipe_halt_monitor: RTL and testbench

- Synthesizable run-control and state-dump block for the pipelined MIPS CPU.
- Sits beside the CPU top and watches the fetch PC each cycle.
- Stops the run on one of NUM_BP programmable PC breakpoints or on a cycle-count timeout.
- After stopping, walks the register file through the CPU debug read port (reg_sel/reg_data) and streams every register out over a valid/ready interface.

---
 rtl/pipe_dbg_pkg.sv | 16 +
 rtl/pipe_bp_match.sv | 24 ++
 rtl/pipe_halt_monitor.sv | 92 +++++++++
 tb/tb_pipe_halt_monitor.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_dbg_pkg.sv
// pipe_dbg_pkg: shared encodings for the pipeline halt/dump monitor
package pipe_dbg_pkg;
  localparam int REG_IDX_W = 5;
  localparam int REG_NUM_DEF = 32;
  typedef enum logic [1:0] {
    CAUSE_NONE = 2'b00,
    CAUSE_BP   = 2'b01,
    CAUSE_TO   = 2'b10
  } cause_e;
  typedef enum logic [1:0] {
    S_RUN   = 2'd0,
    S_FETCH = 2'd1,
    S_SEND  = 2'd2,
    S_DONE  = 2'd3
  } state_e;
endpackage

// File: rtl/pipe_bp_match.sv
// pipe_bp_match: parallel PC breakpoint comparators with lowest-index priority
module pipe_bp_match #(
  parameter int PC_W = 32,
  parameter int NUM_BP = 2
) (
  input  logic                   en,
  input  logic [PC_W-1:0]        pc,
  input  logic                   pc_valid,
  input  logic [NUM_BP*PC_W-1:0] bp_addr,
  input  logic [NUM_BP-1:0]      bp_en,
  output logic                   hit,
  output logic [2:0]             hit_idx
);
  logic [NUM_BP-1:0] m;
  for (genvar i = 0; i < NUM_BP; i++) begin : g_cmp
    assign m[i] = en && pc_valid && bp_en[i] && pc == bp_addr[i*PC_W +: PC_W];
  end
  assign hit = |m;
  // scan from the top so the lowest matching index is the one left standing
  always_comb begin
    hit_idx = '0;
    for (int i = NUM_BP - 1; i >= 0; i--) hit_idx = m[i] ? 3'(i) : hit_idx;
  end
endmodule

// File: rtl/pipe_halt_monitor.sv
// pipe_halt_monitor: halts the CPU on breakpoint/timeout, then streams out the register file
module pipe_halt_monitor
  import pipe_dbg_pkg::*;
#(
  parameter int PC_W = 32,
  parameter int NUM_BP = 2,
  parameter int CNT_W = 16,
  parameter int REG_NUM = REG_NUM_DEF,
  parameter int DATA_W = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic [PC_W-1:0]        pc,
  input  logic                   pc_valid,
  input  logic [NUM_BP*PC_W-1:0] bp_addr,
  input  logic [NUM_BP-1:0]      bp_en,
  input  logic [CNT_W-1:0]       timeout,
  input  logic                   restart,
  output logic [REG_IDX_W-1:0]   reg_sel,
  input  logic [DATA_W-1:0]      reg_data,
  output logic                   dump_valid,
  input  logic                   dump_ready,
  output logic [DATA_W-1:0]      dump_data,
  output logic [REG_IDX_W-1:0]   dump_idx,
  output logic                   halt,
  output logic                   done,
  output logic [1:0]             halt_cause,
  output logic [2:0]             bp_hit_idx,
  output logic [CNT_W-1:0]       cycle_count
);
  state_e state, state_nx;
  logic bp_hit, to_hit, ev, last;
  logic [2:0] bp_idx;
  pipe_bp_match #(.PC_W(PC_W), .NUM_BP(NUM_BP)) u_match (
    .en(en),
    .pc(pc),
    .pc_valid(pc_valid),
    .bp_addr(bp_addr),
    .bp_en(bp_en),
    .hit(bp_hit),
    .hit_idx(bp_idx)
  );
  assign to_hit = en && timeout != '0 && cycle_count == timeout;
  assign ev = state == S_RUN && (bp_hit || to_hit);
  assign last = reg_sel == REG_IDX_W'(REG_NUM - 1);
  assign dump_idx = reg_sel;
  // state register
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= S_RUN;
    else state <= state_nx;
  // next state: run until an event, then alternate fetch/send per register
  always_comb begin
    state_nx = state;
    case (state)
      S_RUN:   state_nx = ev ? S_FETCH : S_RUN;
      S_FETCH: state_nx = S_SEND;
      S_SEND:  state_nx = dump_ready ? (last ? S_DONE : S_FETCH) : S_SEND;
      S_DONE:  state_nx = restart ? S_RUN : S_DONE;
      default: state_nx = S_RUN;
    endcase
  end
  // registered outputs, cycle counter, cause capture and register walk
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      halt <= 1'b0;
      done <= 1'b0;
      dump_valid <= 1'b0;
      dump_data <= '0;
      reg_sel <= '0;
      halt_cause <= CAUSE_NONE;
      bp_hit_idx <= '0;
      cycle_count <= '0;
    end else begin
      halt <= state_nx != S_RUN;
      done <= state_nx == S_DONE;
      dump_valid <= state_nx == S_SEND;
      if (state == S_RUN && en && !ev && cycle_count != '1) cycle_count <= cycle_count + 1'b1;
      if (ev) begin
        halt_cause <= bp_hit ? CAUSE_BP : CAUSE_TO;
        bp_hit_idx <= bp_hit ? bp_idx : 3'd0;
        reg_sel <= '0;
      end
      if (state == S_FETCH) dump_data <= reg_sel == '0 ? '0 : reg_data;
      if (state == S_SEND && dump_ready && !last) reg_sel <= reg_sel + 1'b1;
      if (state == S_DONE && restart) begin
        cycle_count <= '0;
        halt_cause <= CAUSE_NONE;
      end
    end
  end
endmodule

// File: tb/tb_pipe_halt_monitor.sv
// tb_pipe_halt_monitor: randomized scoreboard bench for pipe_halt_monitor
module tb_pipe_halt_monitor;
  localparam int PC_W = 32, NUM_BP = 2, CNT_W = 12, REG_NUM = 32, DATA_W = 32;
  logic clk = 0, rst = 1, en = 0, pc_valid = 0, restart = 0, dump_ready = 0;
  logic [PC_W-1:0] pc = '0;
  logic [NUM_BP*PC_W-1:0] bp_addr = '0;
  logic [NUM_BP-1:0] bp_en = '0;
  logic [CNT_W-1:0] timeout = '0;
  logic [4:0] reg_sel, dump_idx;
  logic [DATA_W-1:0] reg_data, dump_data;
  logic dump_valid, halt, done;
  logic [1:0] halt_cause;
  logic [2:0] bp_hit_idx;
  logic [CNT_W-1:0] cycle_count;
  logic [DATA_W-1:0] rf [REG_NUM];
  typedef struct {
    logic [4:0] idx;
    logic [DATA_W-1:0] data;
  } word_t;
  word_t exp_q[$];
  word_t w, nw;
  int tests = 0, fails = 0, words = 0, n = 0, m_hit;
  bit m_run = 1, m_halt = 0, m_done = 0, last_xfer = 0, m_to;
  bit auto_pc = 0, rand_ready = 0, rand_valid = 0, rand_en = 0;
  logic [CNT_W-1:0] m_cnt = '0;
  logic [1:0] m_cause = '0;
  logic [2:0] m_idx = '0;
  logic p_stall = 0, p_xfer = 0;
  logic [4:0] p_idx = '0;
  logic [DATA_W-1:0] p_data = '0;

  assign reg_data = rf[reg_sel];
  always #5 clk = ~clk;

  pipe_halt_monitor #(.PC_W(PC_W), .NUM_BP(NUM_BP), .CNT_W(CNT_W), .REG_NUM(REG_NUM), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst(rst), .en(en), .pc(pc), .pc_valid(pc_valid), .bp_addr(bp_addr), .bp_en(bp_en),
    .timeout(timeout), .restart(restart), .reg_sel(reg_sel), .reg_data(reg_data),
    .dump_valid(dump_valid), .dump_ready(dump_ready), .dump_data(dump_data), .dump_idx(dump_idx),
    .halt(halt), .done(done), .halt_cause(halt_cause), .bp_hit_idx(bp_hit_idx), .cycle_count(cycle_count)
  );

  task automatic chk(input string nm, input logic [63:0] a, input logic [63:0] e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s: got %0h, want %0h", nm, a, e);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_halt"}, halt, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_valid"}, dump_valid, 0);
    chk({tag, "_reg_sel"}, reg_sel, 0);
    chk({tag, "_dump_idx"}, dump_idx, 0);
    chk({tag, "_dump_data"}, dump_data, 0);
    chk({tag, "_cause"}, halt_cause, 0);
    chk({tag, "_bp_idx"}, bp_hit_idx, 0);
    chk({tag, "_count"}, cycle_count, 0);
  endtask

  // reference model: spec rules evaluated per clock, dump expectations queued on halt
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_run = 1; m_halt = 0; m_done = 0; m_cnt = '0; m_cause = '0; m_idx = '0;
      last_xfer = 0;
      exp_q.delete();
    end else begin
      if (m_run) begin
        m_hit = -1;
        for (int i = NUM_BP - 1; i >= 0; i--)
          if (en && pc_valid && bp_en[i] && pc == bp_addr[i*PC_W +: PC_W]) m_hit = i;
        m_to = en && timeout != 0 && m_cnt == timeout;
        if (m_hit >= 0 || m_to) begin
          m_run = 0; m_halt = 1;
          m_cause = m_hit >= 0 ? 2'b01 : 2'b10;
          m_idx = m_hit >= 0 ? 3'(m_hit) : 3'd0;
          for (int r = 0; r < REG_NUM; r++) begin
            nw.idx = 5'(r);
            nw.data = (r == 0) ? '0 : rf[r];
            exp_q.push_back(nw);
          end
        end else if (en && m_cnt != {CNT_W{1'b1}}) m_cnt = m_cnt + 1'b1;
      end else if (m_done && restart) begin
        m_run = 1; m_halt = 0; m_done = 0; m_cause = '0; m_cnt = '0;
      end
      if (last_xfer) begin
        m_done = 1;
        last_xfer = 0;
      end
    end
  end

  // monitor: status compare every cycle, handshake stability, word scoreboard
  always @(negedge clk or posedge rst) begin
    if (rst) begin
      p_stall = 0;
      p_xfer = 0;
    end else begin
      chk("halt", halt, m_halt);
      chk("done", done, m_done);
      chk("cycle_count", cycle_count, m_cnt);
      chk("halt_cause", halt_cause, m_cause);
      if (m_halt) chk("bp_hit_idx", bp_hit_idx, m_idx);
      else chk("idle_valid", dump_valid, 0);
      if (p_stall) begin
        chk("stall_valid", dump_valid, 1);
        chk("stall_data", dump_data, p_data);
        chk("stall_idx", dump_idx, p_idx);
      end
      if (p_xfer) chk("fetch_gap", dump_valid, 0);
      if (dump_valid && dump_ready) begin
        chk("word_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          w = exp_q.pop_front();
          chk("dump_idx", dump_idx, w.idx);
          chk("dump_data", dump_data, w.data);
          words++;
          if (w.idx == 5'(REG_NUM - 1)) last_xfer = 1;
        end
      end
      p_stall = dump_valid && !dump_ready;
      p_xfer = dump_valid && dump_ready;
      p_idx = dump_idx;
      p_data = dump_data;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (auto_pc && !halt) pc += 4;
    if (rand_ready) dump_ready = ($urandom_range(2) == 0);
    if (rand_valid) pc_valid = ($urandom_range(9) != 0);
    if (rand_en) en = ($urandom_range(6) != 0);
  endtask

  task automatic wait_done(input int lim);
    for (int i = 0; i < lim && !done; i++) tick();
    chk("done_reached", done, 1);
  endtask

  task automatic restart_run();
    restart = 1;
    tick();
    restart = 0;
    chk("restart_halt", halt, 0);
    chk("restart_count", cycle_count, 0);
  endtask

  task automatic rand_rf();
    for (int r = 0; r < REG_NUM; r++) rf[r] = $urandom;
  endtask

  initial begin
    rand_rf();
    bp_addr[0 +: PC_W] = 32'h80;
    bp_en = 2'b01;
    en = 1; pc_valid = 1; dump_ready = 1; auto_pc = 1;
    #3;
    chk_zero("reset");
    #4 rst = 0;
    // breakpoint at 0x80, full-rate dump
    for (int i = 0; i < 200 && !halt; i++) tick();
    chk("bp_halt", halt, 1);
    chk("halt_pc", pc, 32'h80);
    n = 0;
    for (int i = 0; i < 200 && !done; i++) begin
      tick();
      n++;
    end
    chk("dump_cycles", n, 64);
    // timeout at 1000
    bp_en = 2'b00; timeout = 1000; pc = 0;
    rand_rf();
    restart_run();
    wait_done(1500);
    chk("to_count", cycle_count, 1000);
    chk("to_cause", halt_cause, 2'b10);
    // breakpoint and timeout on the same edge, both comparators matching
    bp_addr = {32'h40, 32'h40}; bp_en = 2'b11; timeout = 200; auto_pc = 0; pc = 32'h1000;
    restart_run();
    for (int i = 0; i < 400 && cycle_count != 200; i++) tick();
    pc = 32'h40;
    wait_done(200);
    chk("tie_cause", halt_cause, 2'b01);
    chk("tie_idx", bp_hit_idx, 0);
    // random configs with consumer stalls and flaky enable/valid
    repeat (3) begin
      bp_addr = {PC_W'({$urandom_range(127), 2'b00}), PC_W'({$urandom_range(127), 2'b00})};
      bp_en = 2'($urandom_range(3, 1));
      timeout = CNT_W'($urandom_range(400, 50));
      pc = 0; auto_pc = 1; rand_ready = 1; rand_valid = 1; rand_en = 1;
      rand_rf();
      restart_run();
      wait_done(3000);
    end
    rand_ready = 0; rand_valid = 0; rand_en = 0;
    dump_ready = 1; en = 1; pc_valid = 1;
    // counter saturation, then timeout at all-ones
    bp_en = 2'b00; timeout = 0;
    restart_run();
    repeat (4200) tick();
    chk("sat_count", cycle_count, {CNT_W{1'b1}});
    timeout = {CNT_W{1'b1}};
    wait_done(200);
    chk("sat_cause", halt_cause, 2'b10);
    // asynchronous reset in the middle of the dump
    bp_addr[0 +: PC_W] = 32'h100; bp_en = 2'b01; timeout = 0; pc = 0; rand_ready = 1;
    rand_rf();
    restart_run();
    for (int i = 0; i < 3000; i++) begin
      tick();
      if (dump_valid && dump_idx == 12) break;
    end
    chk("reached_idx12", dump_idx, 12);
    #5 rst = 1;
    #1 chk_zero("midreset");
    rand_ready = 0; dump_ready = 1;
    bp_addr[0 +: PC_W] = 32'h20; bp_en = 2'b01; timeout = 0; pc = 0; auto_pc = 1;
    words = 0;
    #2 rst = 0;
    // fresh dump after reset
    wait_done(300);
    chk("post_reset_cause", halt_cause, 2'b01);
    chk("post_reset_words", words, 32);
    chk("queue_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
